// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ==========================================================================
// alu_sequencer_if : command, host-load, ALU and response signals of alu_sequencer
// Rev 1.0
// ==========================================================================
interface alu_sequencer_if #(
  parameter int REG_AW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_ra;
  logic [REG_AW-1:0] cmd_rb;
  logic [REG_AW-1:0] cmd_rd;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_s;
  logic [7:0]        alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [3:0]        rsp_flags;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    input  wr_en, wr_addr, wr_data,
    input  alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s,
    output rsp_valid, rsp_data, rsp_flags
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    output wr_en, wr_addr, wr_data,
    output alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_data, rsp_flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ==========================================================================
// alu_sequencer : register-file command sequencer driving an 8-bit ALU.
// Optional flag logic built when ALU_SEQ_FLAGS_EN is defined.   Rev 1.0
// ==========================================================================
module alu_sequencer #(
  parameter int REG_AW = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        alu_a_q;
  logic [7:0]        alu_b_q;
  logic [2:0]        alu_s_q;
  logic [REG_AW-1:0] rd_q;
  logic [7:0]        rsp_data_q;

  // Operands are sampled with the pre-write register value when a host load
  // coincides with command accept, because both are non-blocking updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q <= regs_q[bus.cmd_ra];
            alu_b_q <= regs_q[bus.cmd_rb];
            alu_s_q <= bus.cmd_op;
            rd_q    <= bus.cmd_rd;
            state_q <= ISSUE;
          end
          if (bus.wr_en) regs_q[bus.wr_addr] <= bus.wr_data;
        end
        ISSUE: begin
          regs_q[rd_q] <= bus.alu_out;
          rsp_data_q   <= bus.alu_out;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [8:0] sum_d;
  logic       c_d;
  logic       v_d;

  always_comb begin
    sum_d = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (alu_s_q)
      3'b000: begin
        c_d = sum_d[8];
        v_d = (alu_a_q[7] == alu_b_q[7]) && (bus.alu_out[7] != alu_a_q[7]);
      end
      3'b001: begin
        c_d = (alu_a_q < alu_b_q);
        v_d = (alu_a_q[7] != alu_b_q[7]) && (bus.alu_out[7] != alu_a_q[7]);
      end
      3'b110, 3'b111: c_d = alu_a_q[7];
      default: ;
    endcase
    flags_d = {(bus.alu_out == 8'h00), bus.alu_out[7], c_d, v_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == ISSUE) begin
      flags_q <= flags_d;
    end
  end

  assign bus.rsp_flags = flags_q;
`else
  assign bus.rsp_flags = 4'b0000;
`endif

endmodule
`default_nettype wire
